// File: rtl/ps2_scancode_tx.sv
// PS/2 device-side scancode transmitter: make/break sequences as 11-bit frames.
// Ports: Clock, Reset (async high), KeyCode, KeyRelease, Send -> Busy, Done,
// PS2Clk, PS2Data. Macro PS2TX_EXTENDED_EN adds KeyExtended (E0 prefix).
module ps2_scancode_tx #(
  parameter int HALF_PERIOD = 2000,
  parameter int GAP_CYCLES  = 4000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] KeyCode,
  input  logic       KeyRelease,
`ifdef PS2TX_EXTENDED_EN
  input  logic       KeyExtended,
`endif
  input  logic       Send,
  output logic       Busy,
  output logic       Done,
  output logic       PS2Clk,
  output logic       PS2Data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BIT_HI = 2'd1;
  localparam logic [1:0] BIT_LO = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  localparam logic [15:0] HP_LAST  = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [7:0]  BRK      = 8'hF0;

  // start 0, data LSB first, odd parity, stop 1; bit 0 goes out first
  function automatic logic [10:0] frame_of(
    input logic [7:0] b
  );
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  logic [1:0]  state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  bit_idx, bit_idx_n;
  logic [10:0] frame, frame_n;
  logic [15:0] pend, pend_n;
  logic [1:0]  npend, npend_n;
  logic        clk_q, clk_n;
  logic        dat_q, dat_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;

  logic        ext;
  logic        reject;
  logic        accept;
  logic [7:0]  first_b;
  logic [15:0] first_pend;
  logic [1:0]  first_n;

`ifdef PS2TX_EXTENDED_EN
  localparam logic [7:0] EXT = 8'hE0;
  assign ext    = KeyExtended;
  assign reject = (KeyCode == BRK) ||
                  (KeyCode == EXT);
`else
  assign ext    = 1'b0;
  assign reject = (KeyCode == BRK);
`endif

  assign accept = (state == IDLE) &&
                  Send && !reject;

  // Byte list: first byte goes straight into
  // the frame register, the rest wait in pend
  // (low byte next).
  always_comb begin
    first_b    = KeyCode;
    first_pend = 16'h0000;
    first_n    = 2'd0;
`ifdef PS2TX_EXTENDED_EN
    if (ext && KeyRelease) begin
      first_b    = EXT;
      first_pend = {KeyCode, BRK};
      first_n    = 2'd2;
    end else if (ext) begin
      first_b    = EXT;
      first_pend = {8'h00, KeyCode};
      first_n    = 2'd1;
    end else
`endif
    if (KeyRelease && !ext) begin
      first_b    = BRK;
      first_pend = {8'h00, KeyCode};
      first_n    = 2'd1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    bit_idx_n = bit_idx;
    frame_n   = frame;
    pend_n    = pend;
    npend_n   = npend;
    clk_n     = clk_q;
    dat_n     = dat_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        cnt_n  = 16'd0;
        clk_n  = 1'b1;
        dat_n  = 1'b1;
        busy_n = 1'b0;
        if (accept) begin
          state_n   = BIT_HI;
          bit_idx_n = 4'd0;
          frame_n   = frame_of(first_b);
          pend_n    = first_pend;
          npend_n   = first_n;
          dat_n     = 1'b0;
          busy_n    = 1'b1;
        end
      end
      (state == BIT_HI): begin
        if (cnt == HP_LAST) begin
          state_n = BIT_LO;
          cnt_n   = 16'd0;
          clk_n   = 1'b0;
        end
      end
      (state == BIT_LO): begin
        if (cnt == HP_LAST) begin
          cnt_n = 16'd0;
          clk_n = 1'b1;
          if (bit_idx == 4'd10) begin
            dat_n = 1'b1;
            if (npend != 2'd0) begin
              state_n = GAP;
              frame_n = frame_of(pend[7:0]);
              pend_n  = {8'h00, pend[15:8]};
              npend_n = npend - 2'd1;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end else begin
            // frame shifts so the live bit
            // is always at position 0
            state_n   = BIT_HI;
            bit_idx_n = bit_idx + 4'd1;
            frame_n   = {1'b1, frame[10:1]};
            dat_n     = frame[1];
          end
        end
      end
      (state == GAP): begin
        clk_n = 1'b1;
        dat_n = 1'b1;
        if (cnt == GAP_LAST) begin
          state_n   = BIT_HI;
          cnt_n     = 16'd0;
          bit_idx_n = 4'd0;
          dat_n     = frame[0];
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      bit_idx <= 4'd0;
      frame   <= 11'h7FF;
      pend    <= 16'h0000;
      npend   <= 2'd0;
      clk_q   <= 1'b1;
      dat_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      frame   <= frame_n;
      pend    <= pend_n;
      npend   <= npend_n;
      clk_q   <= clk_n;
      dat_q   <= dat_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign PS2Clk  = clk_q;
  assign PS2Data = dat_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: doc/ps2_scancode_tx.md
PS2_SCANCODE_TX -- requirements
Module: ps2_scancode_tx

Interface
- REQ-001 Parameter HALF_PERIOD, default 2000: system-clock cycles per PS2Clk half period (12.5 kHz at 50 MHz); legal range 2..65535.
- REQ-002 Parameter GAP_CYCLES, default 4000: idle cycles between consecutive frames of one multi-byte sequence; legal range 1..65535.
- REQ-003 Clock  input  1  system clock; all logic on its rising edge.
- REQ-004 Reset  input  1  asynchronous, active-high reset.
- REQ-005 KeyCode  input  8  make code to transmit; sampled when Send is accepted.
- REQ-006 KeyRelease  input  1  1 = send break sequence (8'hF0 then KeyCode); 0 = send KeyCode only; sampled with KeyCode.
- REQ-007 Send  input  1  single-cycle or level request; accepted only when Busy=0.
- REQ-008 Busy  output  1  high from the cycle after acceptance until Done.
- REQ-009 Done  output  1  one-cycle pulse when the whole sequence has been sent.
- REQ-010 PS2Clk  output  1  device-generated PS/2 clock; idle high.
- REQ-011 PS2Data  output  1  PS/2 data line; idle high.

Function
- REQ-012 Each frame SHALL be 11 bits: start 0, eight data bits LSB first, odd-parity bit (XNOR-reduce of data), stop 1.
- REQ-013 States SHALL be IDLE, BIT_HI, BIT_LO, GAP.
- REQ-014 IDLE: PS2Clk=1, PS2Data=1, Busy=0; Send=1 and KeyCode!=8'hF0 SHALL latch inputs and move to BIT_HI with bit index 0 on the next edge.
- REQ-015 Send with KeyCode==8'hF0 SHALL be ignored: no Busy, no Done, no frame.
- REQ-016 BIT_HI: PS2Data SHALL present the current bit from the first cycle of the state; PS2Clk=1 for exactly HALF_PERIOD cycles, then BIT_LO.
- REQ-017 BIT_LO: PS2Data held; PS2Clk=0 for exactly HALF_PERIOD cycles; then next bit in BIT_HI, or after bit 10 go to GAP (more bytes pending) or IDLE (last byte).
- REQ-018 PS2Data SHALL change only in the first cycle of BIT_HI, never while PS2Clk=0.
- REQ-019 One frame SHALL take exactly 22*HALF_PERIOD cycles; first start-bit cycle is the cycle after Send is accepted.
- REQ-020 GAP: PS2Clk=1, PS2Data=1 for exactly GAP_CYCLES cycles, then BIT_HI for the next byte.
- REQ-021 Byte order: KeyRelease=1 -> 8'hF0, KeyCode; KeyRelease=0 -> KeyCode.
- REQ-022 Done SHALL pulse in the first IDLE cycle after the last frame; Busy SHALL be 0 in that same cycle.
- REQ-023 Send asserted while Busy=1 SHALL be ignored and not queued; KeyCode/KeyRelease changes during Busy SHALL not affect the sequence.
- REQ-024 Send asserted in the Done cycle SHALL be accepted (back-to-back sequences allowed).
- REQ-025 Half-period and gap counters SHALL be 16 bits and reset to 0 on every state entry.

Reset
- REQ-026 Reset SHALL force, immediately and asynchronously: state IDLE, PS2Clk=1, PS2Data=1, Busy=0, Done=0, counters and bit index 0.
- REQ-027 Reset mid-frame SHALL abandon the frame with no Done; the first Send after reset release SHALL start a fresh sequence.

Configuration
- REQ-028 Macro PS2TX_EXTENDED_EN SHALL add input KeyExtended (1 bit, sampled with KeyCode).
- REQ-029 With PS2TX_EXTENDED_EN defined, KeyExtended=1 SHALL prefix 8'hE0: order E0,KeyCode (make) or E0,F0,KeyCode (break), GAP between each frame; Send with KeyCode==8'hE0 SHALL also be ignored.
- REQ-030 Without PS2TX_EXTENDED_EN, the port does not exist and behaviour is exactly REQ-021.

Verification (HALF_PERIOD=4, GAP_CYCLES=6)
- REQ-031 Make: Send, KeyCode=8'h1C, KeyRelease=0 -> PS2Data per falling edge 0,0,0,1,1,1,0,0,0,0,1; Done at cycle 89 after acceptance.
- REQ-032 Break: KeyCode=8'h1C, KeyRelease=1 -> frame F0 (0,0,0,0,0,1,1,1,1,1,1), 6 idle-high cycles, frame 1C; Done after 88+6+88 cycles.
- REQ-033 Send pulses during Busy and Send with KeyCode=8'hF0 while idle -> no extra frames, no Done.
- REQ-034 Reset asserted during bit 5 of a frame -> PS2Clk=1, PS2Data=1, Busy=0 with no clock edge; no Done; next Send sends full frame.
- REQ-035 Send held high continuously with KeyCode=8'h1C -> back-to-back frames, Send accepted in each Done cycle.
- REQ-036 PS2TX_EXTENDED_EN, KeyExtended=1, KeyRelease=1, KeyCode=8'h75 -> frames E0, F0, 75 with 6-cycle gaps, single Done.
